// File: rtl/input_pkg.sv
// Shared constants for the board input conditioner: pin index map, defaults
// and the per-bit debounce state encoding.
package input_pkg;

  localparam int N_IN_DEFAULT  = 13;
  localparam int JA_BASE       = 0;
  localparam int JA_WIDTH      = 12;
  localparam int BTNR_IDX      = 12;
  localparam int DEBOUNCE_10MS = 1_000_000;
  localparam int CNT_W_DEFAULT = 20;
  localparam int SYNC_DEFAULT  = 2;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// One conditioned input: multi-flop synchronizer, counter debounce FSM and
// registered rise/fall pulses. rise_next_o is the pulse one cycle early.
module debounce_bit
  import input_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int CNT_W           = CNT_W_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o,
  output logic rise_next_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit SINGLE_CYCLE = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;
  db_state_e              state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   stable_q;
  logic                   rise_q;
  logic                   fall_q;

  logic differ;
  logic toggle_d;
  logic rise_d;
  logic fall_d;

  assign sync_bit = sync_q[SYNC_STAGES-1];
  assign differ   = (sync_bit != stable_q);

  // The first differing sample already counts as one held cycle, so a
  // single-cycle debounce toggles straight from STABLE.
  always_comb begin
    toggle_d = 1'b0;
    if (differ) begin
      if (state_q == ST_STABLE) begin
        toggle_d = SINGLE_CYCLE;
      end else begin
        toggle_d = (cnt_q == CNT_LAST);
      end
    end
    rise_d = toggle_d & ~stable_q;
    fall_d = toggle_d & stable_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q   <= '0;
      state_q  <= ST_STABLE;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i ^ ACTIVE_LOW};
      rise_q <= rise_d;
      fall_q <= fall_d;
      if (toggle_d) begin
        stable_q <= ~stable_q;
      end
      case (state_q)
        ST_STABLE: begin
          if (differ && !toggle_d) begin
            cnt_q   <= CNT_W'(1);
            state_q <= ST_PENDING;
          end else begin
            cnt_q <= '0;
          end
        end
        ST_PENDING: begin
          if (!differ || toggle_d) begin
            cnt_q   <= '0;
            state_q <= ST_STABLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_STABLE;
        end
      endcase
    end
  end

  assign stable_o    = stable_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign rise_next_o = rise_d;

endmodule

// File: rtl/input_conditioner.sv
// Conditions the asynchronous board inputs (JA[11:0], BTNR): per-bit debounce
// plus sticky rise-event flags that software polls and clears by mask.
module input_conditioner
  import input_pkg::*;
#(
  parameter int N_IN            = N_IN_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int CNT_W           = CNT_W_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_IN-1:0] raw_in,
  input  logic            clear_en,
  input  logic [N_IN-1:0] clear_mask,
  output logic [N_IN-1:0] stable_out,
  output logic [N_IN-1:0] rise_pulse,
  output logic [N_IN-1:0] fall_pulse,
  output logic [N_IN-1:0] event_flag,
  output logic            event_any
);

  logic [N_IN-1:0] rise_next;
  logic [N_IN-1:0] clear_sel;
  logic [N_IN-1:0] event_flag_d;
  logic [N_IN-1:0] event_flag_q;
  logic            event_any_q;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_debounce (
      .clock      (clock),
      .reset      (reset),
      .raw_i      (raw_in[gi]),
      .stable_o   (stable_out[gi]),
      .rise_o     (rise_pulse[gi]),
      .fall_o     (fall_pulse[gi]),
      .rise_next_o(rise_next[gi])
    );
  end

  // A rise landing in the same cycle as a clear keeps the flag set.
  assign clear_sel    = {N_IN{clear_en}} & clear_mask;
  assign event_flag_d = rise_next | (event_flag_q & ~clear_sel);

  always_ff @(posedge clock) begin
    if (reset) begin
      event_flag_q <= '0;
      event_any_q  <= 1'b0;
    end else begin
      event_flag_q <= event_flag_d;
      event_any_q  <= |event_flag_d;
    end
  end

  assign event_flag = event_flag_q;
  assign event_any  = event_any_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Randomized and directed checks of input_conditioner against a window-based
// reference model: a level change is accepted after DEB consecutive synced samples.
module tb_input_conditioner;

  localparam int N    = 13;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int CW   = 3;
  localparam int MAXC = 4096;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  raw_in;
  logic          clear_en;
  logic [N-1:0]  clear_mask;
  logic [N-1:0]  stable_out;
  logic [N-1:0]  rise_pulse;
  logic [N-1:0]  fall_pulse;
  logic [N-1:0]  event_flag;
  logic          event_any;

  input_conditioner #(
    .N_IN           (N),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW),
    .ACTIVE_LOW     (1'b0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .raw_in    (raw_in),
    .clear_en  (clear_en),
    .clear_mask(clear_mask),
    .stable_out(stable_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .event_flag(event_flag),
    .event_any (event_any)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [N-1:0] raw_at    [0:MAXC-1];
  logic [N-1:0] seen_hist [0:MAXC-1];
  int           cyc      = 0;
  int           last_rst = 0;
  logic [N-1:0] m_stable = '0;
  logic [N-1:0] m_rise   = '0;
  logic [N-1:0] m_fall   = '0;
  logic [N-1:0] m_flag   = '0;
  logic         m_any    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock edge: record the inputs it samples, advance the model, compare.
  task automatic tick();
    logic         r;
    logic         ce;
    logic [N-1:0] cm;
    logic [N-1:0] tog;
    logic         all_diff;
    int           e;
    r  = reset;
    ce = clear_en;
    cm = clear_mask;
    raw_at[cyc] = raw_in;
    @(posedge clock);
    cyc++;
    e = cyc;
    if (r) begin
      last_rst     = e;
      seen_hist[e] = '0;
      m_stable     = '0;
      m_rise       = '0;
      m_fall       = '0;
      m_flag       = '0;
      m_any        = 1'b0;
    end else begin
      // Value the debouncer sees at this edge: raw delayed by the synchronizer,
      // zero while the post-reset pipeline is still refilling.
      for (int i = 0; i < N; i++) begin
        seen_hist[e][i] = (e - 1 - SYNC >= last_rst) ? raw_at[e - 1 - SYNC][i] : 1'b0;
      end
      tog = '0;
      for (int i = 0; i < N; i++) begin
        if (e - DEB + 1 > last_rst) begin
          all_diff = 1'b1;
          for (int k = e - DEB + 1; k <= e; k++) begin
            if (seen_hist[k][i] == m_stable[i]) all_diff = 1'b0;
          end
          tog[i] = all_diff;
        end
      end
      m_rise   = tog & ~m_stable;
      m_fall   = tog & m_stable;
      m_stable = m_stable ^ tog;
      m_flag   = m_rise | (m_flag & ~(ce ? cm : '0));
      m_any    = |m_flag;
    end
    #1;
    check("stable_out", 32'(stable_out), 32'(m_stable));
    check("rise_pulse", 32'(rise_pulse), 32'(m_rise));
    check("fall_pulse", 32'(fall_pulse), 32'(m_fall));
    check("event_flag", 32'(event_flag), 32'(m_flag));
    check("event_any",  32'(event_any),  32'(m_any));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    clear_en   = 1'b0;
    clear_mask = '0;
    raw_in     = 13'h1FFF;

    // Reset held 3 cycles with all inputs high
    repeat (3) begin
      tick();
      check("rst_stable", 32'(stable_out), 32'h0);
      check("rst_flag",   32'(event_flag), 32'h0);
      check("rst_any",    32'(event_any),  32'h0);
    end
    reset  = 1'b0;
    raw_in = '0;
    tick();
    check("post_rst_stable", 32'(stable_out), 32'h0);
    check("post_rst_rise",   32'(rise_pulse), 32'h0);
    check("post_rst_any",    32'(event_any),  32'h0);
    repeat (6) tick();
    $display("scenario reset: checks=%0d passed=%0d", n_checks, n_pass);

    // Bit 0 rises and is held
    raw_in[0] = 1'b1;
    repeat (5) tick();
    check("s2_stable0_early", 32'(stable_out[0]), 32'h0);
    tick();
    check("s2_stable0", 32'(stable_out[0]), 32'h1);
    check("s2_rise0",   32'(rise_pulse[0]), 32'h1);
    check("s2_flag0",   32'(event_flag[0]), 32'h1);
    check("s2_any",     32'(event_any),     32'h1);
    tick();
    check("s2_rise0_end", 32'(rise_pulse[0]), 32'h0);
    $display("scenario rise: checks=%0d passed=%0d", n_checks, n_pass);

    // Three-cycle glitch on bit 3
    raw_in[3] = 1'b1;
    repeat (3) tick();
    raw_in[3] = 1'b0;
    repeat (8) begin
      tick();
      check("s3_stable3", 32'(stable_out[3]), 32'h0);
      check("s3_rise3",   32'(rise_pulse[3]), 32'h0);
      check("s3_flag3",   32'(event_flag[3]), 32'h0);
    end
    $display("scenario glitch: checks=%0d passed=%0d", n_checks, n_pass);

    // Flags 0 and 2 set, then clear bit 0 only
    raw_in[2] = 1'b1;
    repeat (8) tick();
    check("s4_flags", 32'(event_flag), 32'h0005);
    clear_en   = 1'b1;
    clear_mask = 13'h0001;
    tick();
    clear_en   = 1'b0;
    clear_mask = 13'h1FFF;
    check("s4_cleared", 32'(event_flag), 32'h0004);
    tick();
    check("s4_mask_ignored", 32'(event_flag), 32'h0004);
    clear_mask = '0;
    $display("scenario clear: checks=%0d passed=%0d", n_checks, n_pass);

    // Release bit 0
    raw_in[0] = 1'b0;
    repeat (5) tick();
    check("s5_fall0_early", 32'(fall_pulse[0]), 32'h0);
    tick();
    check("s5_fall0",   32'(fall_pulse[0]), 32'h1);
    check("s5_stable0", 32'(stable_out[0]), 32'h0);
    check("s5_flags",   32'(event_flag),    32'h0004);
    tick();
    check("s5_fall0_end", 32'(fall_pulse[0]), 32'h0);
    $display("scenario release: checks=%0d passed=%0d", n_checks, n_pass);

    // Clear coinciding with a new rise on bit 0: set wins, bit 2 clears
    raw_in[0] = 1'b1;
    repeat (5) tick();
    clear_en   = 1'b1;
    clear_mask = 13'h0005;
    tick();
    clear_en   = 1'b0;
    clear_mask = '0;
    check("s4b_rise0", 32'(rise_pulse[0]), 32'h1);
    check("s4b_flags", 32'(event_flag),    32'h0001);
    $display("scenario set_wins: checks=%0d passed=%0d", n_checks, n_pass);

    // Reset in the middle of a bit-12 debounce
    raw_in[12] = 1'b1;
    repeat (3) tick();
    check("s6_pre_rise12", 32'(rise_pulse[12]), 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("s6_rst_stable12", 32'(stable_out[12]), 32'h0);
    repeat (5) begin
      tick();
      check("s6_wait_stable12", 32'(stable_out[12]), 32'h0);
      check("s6_wait_rise12",   32'(rise_pulse[12]), 32'h0);
    end
    tick();
    check("s6_stable12", 32'(stable_out[12]), 32'h1);
    check("s6_rise12",   32'(rise_pulse[12]), 32'h1);
    $display("scenario reset_mid: checks=%0d passed=%0d", n_checks, n_pass);

    // Randomized traffic: sparse flips, occasional all-bit flips, clears, resets
    for (int t = 0; t < 2000; t++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) begin
        raw_in = ~raw_in;
      end else begin
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 5) == 0) raw_in[i] = ~raw_in[i];
        end
      end
      clear_en   = ($urandom_range(0, 7) == 0);
      clear_mask = N'($urandom);
      tick();
    end
    reset    = 1'b0;
    clear_en = 1'b0;
    $display("scenario random: checks=%0d passed=%0d", n_checks, n_pass);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
